// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: state encoding,
// CSR addresses, cause codes, system-instruction encodings and mstatus helpers.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SAVE_EPC    = 3'd1,
        ST_SAVE_CAUSE  = 3'd2,
        ST_SAVE_STATUS = 3'd3,
        ST_MRET_STATUS = 3'd4,
        ST_JUMP        = 3'd5
    } trap_state_e;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Vector slot used by the machine external interrupt in vectored mode.
    localparam int IRQ_VEC_IDX = 11;

    function automatic logic [31:0] mstatus_enter_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_leave_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_decode.sv
// Combinational classification of the decode-stage instruction into
// ecall / ebreak / mret.
module trap_decode
    import trap_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        is_ecall_o,
    output logic        is_ebreak_o,
    output logic        is_mret_o
);

    assign is_ecall_o  = (inst_i == INST_ECALL);
    assign is_ebreak_o = (inst_i == INST_EBREAK);
    assign is_mret_o   = (inst_i == INST_MRET);

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/mstatus over successive
// cycles, then redirects. Define TRAP_VECTORED_EN for vectored interrupt entry.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int MTVEC_ALIGN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        irq_i,
    input  logic        jump_ena_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_flag_o,
    output logic        jump_ena_o,
    output logic [31:0] jump_addr_o
);

    logic is_ecall, is_ebreak, is_mret;

    trap_decode u_decode (
        .inst_i      (inst_i),
        .is_ecall_o  (is_ecall),
        .is_ebreak_o (is_ebreak),
        .is_mret_o   (is_mret)
    );

    trap_state_e state_q, state_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        mret_q, mret_d;
    logic        irq_q, irq_d;

    logic        sync_evt, irq_evt, accept;
    logic [31:0] trap_base, trap_target;

    // A flushed instruction must not raise a synchronous trap.
    assign sync_evt  = (is_ecall | is_ebreak | is_mret) & ~jump_ena_i;
    assign irq_evt   = irq_i & csr_mstatus_i[MSTATUS_MIE];
    assign trap_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign trap_target = (irq_q && (csr_mtvec_i[1:0] == 2'b01))
                       ? trap_base + 32'(MTVEC_ALIGN * IRQ_VEC_IDX)
                       : trap_base;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{irq_q, csr_mtvec_i[1:0], 32'(MTVEC_ALIGN)};
    assign trap_target = trap_base;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mret_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mret_q   <= mret_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mret_d      = mret_q;
        irq_d       = irq_q;
        accept      = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_flag_o = 1'b0;
        jump_ena_o  = 1'b0;
        jump_addr_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!hold_flag_i) begin
                    if (sync_evt) begin
                        accept = 1'b1;
                        if (is_mret) begin
                            state_d = ST_MRET_STATUS;
                            mret_d  = 1'b1;
                        end else begin
                            state_d  = ST_SAVE_EPC;
                            mret_d   = 1'b0;
                            irq_d    = 1'b0;
                            mepc_d   = inst_addr_i;
                            mcause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        end
                    end else if (irq_evt) begin
                        accept   = 1'b1;
                        state_d  = ST_SAVE_EPC;
                        mret_d   = 1'b0;
                        irq_d    = 1'b1;
                        mepc_d   = jump_ena_i ? jump_addr_i : inst_addr_i;
                        mcause_d = CAUSE_IRQ;
                    end
                end
                // Accept stalls the pipeline in the same cycle; suppressed under reset.
                hold_flag_o = accept & rst_n;
            end
            ST_SAVE_EPC: begin
                state_d     = ST_SAVE_CAUSE;
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = mepc_q;
            end
            ST_SAVE_CAUSE: begin
                state_d     = ST_SAVE_STATUS;
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = mcause_q;
            end
            ST_SAVE_STATUS: begin
                state_d     = ST_JUMP;
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_enter_trap(csr_mstatus_i);
            end
            ST_MRET_STATUS: begin
                state_d     = ST_JUMP;
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_leave_trap(csr_mstatus_i);
            end
            ST_JUMP: begin
                state_d     = ST_IDLE;
                hold_flag_o = 1'b1;
                jump_ena_o  = 1'b1;
                jump_addr_o = mret_q ? csr_mepc_i : trap_target;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// traffic, all checked against a queue-based action model.
module tb_trap_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef TRAP_VECTORED_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst, inst_addr, jump_addr, mtvec, mepc, mstatus;
    logic        irq, jump_ena, hold_in;
    logic        csr_we, hold_o, jena_o;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, jaddr_o;

    always #5 clk = ~clk;

    trap_ctrl #(.MTVEC_ALIGN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_i        (inst),
        .inst_addr_i   (inst_addr),
        .irq_i         (irq),
        .jump_ena_i    (jump_ena),
        .jump_addr_i   (jump_addr),
        .hold_flag_i   (hold_in),
        .csr_mtvec_i   (mtvec),
        .csr_mepc_i    (mepc),
        .csr_mstatus_i (mstatus),
        .csr_we_o      (csr_we),
        .csr_waddr_o   (csr_waddr),
        .csr_wdata_o   (csr_wdata),
        .hold_flag_o   (hold_o),
        .jump_ena_o    (jena_o),
        .jump_addr_o   (jaddr_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: a queue of pending actions (1 save epc, 2 save cause,
    // 3 trap status, 4 mret status, 5 jump) filled when an event is taken.
    int          q[$];
    logic [31:0] m_epc, m_cause;
    bit          m_mret, m_irq;

    task automatic model_check(input string tag);
        logic        e_hold, e_we, e_jen;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata, e_jaddr;
        bit          sync, irq_ok;
        int          s;
        e_hold = 0; e_we = 0; e_jen = 0; e_waddr = 0; e_wdata = 0; e_jaddr = 0;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            sync   = ((inst == ECALL) || (inst == EBREAK) || (inst == MRET)) && !jump_ena;
            irq_ok = irq && mstatus[3];
            if (!hold_in && (sync || irq_ok)) begin
                e_hold = 1;
                if (sync && inst == MRET) begin
                    m_mret = 1;
                    q = {4, 5};
                end else begin
                    m_mret  = 0;
                    m_irq   = !sync;
                    m_epc   = sync ? inst_addr : (jump_ena ? jump_addr : inst_addr);
                    m_cause = !sync ? 32'h8000_000B : (inst == ECALL ? 32'd11 : 32'd3);
                    q = {1, 2, 3, 5};
                end
            end
        end else begin
            s = q.pop_front();
            e_hold = 1;
            case (s)
                1: begin e_we = 1; e_waddr = 12'h341; e_wdata = m_epc; end
                2: begin e_we = 1; e_waddr = 12'h342; e_wdata = m_cause; end
                3: begin e_we = 1; e_waddr = 12'h300;
                         e_wdata = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0); end
                4: begin e_we = 1; e_waddr = 12'h300;
                         e_wdata = (mstatus & ~32'h08) | 32'h80 | (mstatus[7] ? 32'h08 : 32'h0); end
                default: begin
                    e_jen = 1;
                    if (m_mret) e_jaddr = mepc;
                    else if (VEC_EN && m_irq && mtvec[1:0] == 2'b01) e_jaddr = (mtvec & ~32'h3) + 32'd44;
                    else e_jaddr = mtvec & ~32'h3;
                end
            endcase
        end
        check({tag, ".hold"},  32'(hold_o),    32'(e_hold));
        check({tag, ".we"},    32'(csr_we),    32'(e_we));
        check({tag, ".waddr"}, 32'(csr_waddr), 32'(e_waddr));
        check({tag, ".wdata"}, csr_wdata,      e_wdata);
        check({tag, ".jen"},   32'(jena_o),    32'(e_jen));
        check({tag, ".jaddr"}, jaddr_o,        e_jaddr);
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(tag);
            next();
        end
    endtask

    task automatic idle_inputs();
        inst = NOP; inst_addr = 32'h0; irq = 0; jump_ena = 0; jump_addr = 32'h0;
        hold_in = 0; mtvec = 32'h200; mepc = 32'h0; mstatus = 32'h0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        inst = ECALL;
        cyc("reset");
        check("reset_hold", 32'(hold_o), 32'h0);
        check("reset_jen", 32'(jena_o), 32'h0);
        next();
        inst = NOP;
        rst_n = 1;
        run("idle", 2);

        // ecall at 0x100, mtvec 0x200
        inst = ECALL; inst_addr = 32'h100; mstatus = 32'h8;
        cyc("ecall0"); check("ecall_c0_hold", 32'(hold_o), 32'h1); next();
        inst = NOP;
        cyc("ecall1"); check("ecall_mepc", csr_wdata, 32'h100); next();
        cyc("ecall2"); check("ecall_mcause", csr_wdata, 32'd11); next();
        cyc("ecall3"); check("ecall_mstatus", csr_wdata, 32'h80); next();
        cyc("ecall4"); check("ecall_jaddr", jaddr_o, 32'h200); next();
        cyc("ecall5"); check("ecall_c5_hold", 32'(hold_o), 32'h0); next();

        // irq while ex-stage redirects to 0x80
        irq = 1; mstatus = 32'h8; jump_ena = 1; jump_addr = 32'h80; inst_addr = 32'h40;
        cyc("irq0"); next();
        irq = 0; jump_ena = 0;
        cyc("irq1"); check("irq_mepc", csr_wdata, 32'h80); next();
        cyc("irq2"); check("irq_mcause", csr_wdata, 32'h8000_000B); next();
        run("irq", 3);
        irq = 1; mstatus = 32'h0;
        run("irq_mie0", 3);
        irq = 0;

        // mret
        inst = MRET; mepc = 32'h104; mstatus = 32'h80;
        cyc("mret0"); next();
        inst = NOP;
        cyc("mret1"); check("mret_mstatus", csr_wdata, 32'h88); next();
        cyc("mret2"); check("mret_jaddr", jaddr_o, 32'h104); next();
        cyc("mret3"); check("mret_c3_hold", 32'(hold_o), 32'h0); next();

        // ecall and irq together: ecall wins, irq masked afterwards
        inst = ECALL; irq = 1; mstatus = 32'h8; inst_addr = 32'h300;
        cyc("both0"); next();
        inst = NOP;
        cyc("both1"); next();
        cyc("both2"); check("both_mcause", csr_wdata, 32'd11); next();
        cyc("both3"); next();
        mstatus = 32'h80;
        cyc("both4"); next();
        cyc("both5"); check("both_no_irq", 32'(hold_o), 32'h0); next();
        irq = 0;

        // hold_flag_i defers accept
        inst = ECALL; hold_in = 1;
        for (int i = 0; i < 3; i++) begin
            cyc("held"); check("held_hold", 32'(hold_o), 32'h0); next();
        end
        hold_in = 0;
        cyc("held_acc"); check("held_accept", 32'(hold_o), 32'h1); next();
        inst = NOP;
        run("held_seq", 5);

        // flushed ecall ignored
        inst = ECALL; jump_ena = 1;
        cyc("flush"); check("flush_ignored", 32'(hold_o), 32'h0); next();
        inst = NOP; jump_ena = 0;
        run("flush_after", 2);

        // reset during SAVE_CAUSE
        inst = ECALL; inst_addr = 32'h500;
        cyc("rst0"); next();
        inst = NOP;
        cyc("rst1"); next();
        cyc("rst2"); check("rst_in_cause", 32'(csr_waddr), 32'h342);
        #2 rst_n = 0;
        #1 check("rst_async_we", 32'(csr_we), 32'h0);
        cyc("rst_low"); next();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc("rst_after"); check("rst_no_jump", 32'(jena_o), 32'h0); next();
        end

        // irq with mtvec mode bits 01
        mtvec = 32'h201; irq = 1; mstatus = 32'h8;
        cyc("vec0"); next();
        irq = 0;
        run("vec", 3);
        cyc("vec4"); check("vec_jaddr", jaddr_o, VEC_EN ? 32'h22C : 32'h200); next();
        run("vec_after", 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0: inst = ECALL;
                1: inst = EBREAK;
                2: inst = MRET;
                default: inst = $urandom();
            endcase
            inst_addr = $urandom();
            irq       = ($urandom_range(0, 2) == 0);
            jump_ena  = ($urandom_range(0, 4) == 0);
            jump_addr = $urandom();
            hold_in   = ($urandom_range(0, 4) == 0);
            mtvec     = ($urandom_range(0, 1) == 0) ? (($urandom() & ~32'h3) | 32'h1) : $urandom();
            mepc      = $urandom();
            mstatus   = $urandom();
            if ($urandom_range(0, 199) == 0) rst_n = 0;
            cyc("rand");
            next();
            rst_n = 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
